vga_sprite_renderer: RTL and testbench

- Parametrised, pipelined successor to the combinational pixel formatter: maps the current VGA pixel to a 3-bit colour from tile-grid game state (bullet, ship, multi-row invader block, explosions).
- Adds registered output, two-frame invader animation, a timed explosion sprite, attract-mode checkerboard and out-of-grid blanking.
- Sits between the VGA timing generator (VGAx/VGAy/frameStart) and the DAC pins; the game-logic FSM drives all state inputs.

---
 rtl/vga_pkg.sv | 23 ++
 rtl/vga_sprite_rom.sv | 52 +++++
 rtl/vga_sprite_renderer.sv | 168 ++++++++++++++++
 tb/tb_vga_sprite_renderer.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared colour codes, object selects and width helpers for the VGA sprite renderer.
package vga_pkg;

   localparam logic [2:0] BLACK   = 3'b000;
   localparam logic [2:0] BLUE    = 3'b001;
   localparam logic [2:0] GREEN   = 3'b010;
   localparam logic [2:0] CYAN    = 3'b011;
   localparam logic [2:0] RED     = 3'b100;
   localparam logic [2:0] MAGENTA = 3'b101;
   localparam logic [2:0] YELLOW  = 3'b110;
   localparam logic [2:0] WHITE   = 3'b111;

   typedef enum logic [2:0] {OFF, BG, CHECK, BULLET, EXPLODE, SHIP, INVADER} obj_e;

   function automatic int cw_x(input int cols);
      return (cols > 1) ? $clog2(cols) : 1;
   endfunction

   function automatic int cw_y(input int rows);
      return (rows > 1) ? $clog2(rows) : 1;
   endfunction

endpackage

// File: rtl/vga_sprite_rom.sv
// Combinational 32x32 sprite bitmaps (bullet, ship, explosion, two invader frames).
// Tiles of other sizes are rescaled onto the 32x32 grid.
module vga_sprite_rom
   import vga_pkg::*;
#(
   parameter int TILE_LOG2 = 5
) (
   input  obj_e                 sprite,
   input  logic                 anim_frame,
   input  logic [TILE_LOG2-1:0] py,
   input  logic [TILE_LOG2-1:0] px,
   output logic                 on
);

   logic [4:0] x;
   logic [4:0] y;
   int         xi;
   int         yi;

   generate
      if (TILE_LOG2 >= 5) begin : g_down
         assign x = px[TILE_LOG2-1:TILE_LOG2-5];
         assign y = py[TILE_LOG2-1:TILE_LOG2-5];
      end else begin : g_up
         assign x = {px, {(5-TILE_LOG2){1'b0}}};
         assign y = {py, {(5-TILE_LOG2){1'b0}}};
      end
   endgenerate

   assign xi = 32'(x);
   assign yi = 32'(y);

   always_comb begin
      on = 1'b0;
      case (sprite)
         BULLET:  on = (xi >= 14 && xi <= 17 && yi >= 4 && yi <= 27);
         SHIP:    on = (yi >= 16 && yi <= 27 && xi >= 2 && xi <= 29) ||
                       (yi >= 6 && yi <= 15 && xi >= 13 && xi <= 18);
         EXPLODE: on = (xi - yi <= 2 && yi - xi <= 2) || (xi + yi >= 29 && xi + yi <= 33);
         INVADER: begin
            // body with two eye holes; legs swing between the two frames
            on = (yi >= 8 && yi <= 19 && xi >= 6 && xi <= 25) &&
                 !(yi >= 11 && yi <= 13 && ((xi >= 10 && xi <= 12) || (xi >= 19 && xi <= 21)));
            if (yi >= 20 && yi <= 25)
               on = anim_frame ? ((xi >= 11 && xi <= 13) || (xi >= 18 && xi <= 20))
                               : ((xi >= 6 && xi <= 8) || (xi >= 23 && xi <= 25));
         end
         default: on = 1'b0;
      endcase
   end

endmodule

// File: rtl/vga_sprite_renderer.sv
// Two-stage pipelined tile renderer: stage 1 picks the object under the pixel,
// stage 2 looks up the sprite bit and drives the registered colour.
module vga_sprite_renderer
   import vga_pkg::*;
#(
   parameter int TILE_LOG2      = 5,
   parameter int COLS           = 20,
   parameter int ROWS           = 15,
   parameter int INV_ROWS       = 3,
   parameter int SHIP_ROW       = 13,
   parameter int ANIM_DIV       = 30,
   parameter int EXPLODE_FRAMES = 8
) (
   input  logic                      clk,
   input  logic                      clr,
   input  logic [9:0]                VGAx,
   input  logic [9:0]                VGAy,
   input  logic                      frameStart,
   input  logic                      attract,
   input  logic [INV_ROWS*COLS-1:0]  invArray,
   input  logic [cw_y(ROWS)-1:0]     invLine,
   input  logic [cw_x(COLS)-1:0]     shipX,
   input  logic [cw_x(COLS)-1:0]     bulletX,
   input  logic [cw_y(ROWS)-1:0]     bulletY,
   input  logic                      bulletFlying,
   input  logic                      hitValid,
   input  logic [cw_x(COLS)-1:0]     hitX,
   input  logic [cw_y(ROWS)-1:0]     hitY,
   output logic [2:0]                rgb,
   output logic                      animFrame,
   output logic                      exploding
);

   localparam int CWX = cw_x(COLS);
   localparam int CWY = cw_y(ROWS);
   localparam int TW  = 10 - TILE_LOG2;
   localparam int IW  = cw_x(INV_ROWS * COLS);
   localparam int AW  = cw_x(ANIM_DIV);
   localparam int EW  = $clog2(EXPLODE_FRAMES + 1);

   typedef enum logic {IDLE, ACTIVE} xstate_e;

   logic [TW-1:0]        tx, ty;
   logic [TILE_LOG2-1:0] px, py;
   logic [CWY:0]         inv_diff;
   logic [IW-1:0]        inv_idx;
   obj_e                 obj_next;

   logic                 valid_reg;
   obj_e                 obj_reg;
   logic                 par_reg;
   logic                 frame_reg;
   logic [TILE_LOG2-1:0] px_reg, py_reg;
   logic                 rom_bit;
   logic [2:0]           rgb_next;

   logic [AW-1:0]        anim_cnt_reg;
   xstate_e              xstate_reg;
   logic [EW-1:0]        xcnt_reg;
   logic [CWX-1:0]       hitx_reg;
   logic [CWY-1:0]       hity_reg;

   assign tx = VGAx[9:TILE_LOG2];
   assign ty = VGAy[9:TILE_LOG2];
   assign px = VGAx[TILE_LOG2-1:0];
   assign py = VGAy[TILE_LOG2-1:0];

   always_comb begin
      // one extra bit so rows above the formation come out negative
      inv_diff = {1'b0, ty[CWY-1:0]} - {1'b0, invLine};
      inv_idx  = IW'(32'(inv_diff) * COLS + 32'(tx));
      if (attract)
         obj_next = CHECK;
      else if (32'(tx) >= COLS || 32'(ty) >= ROWS)
         obj_next = OFF;
      else if (bulletFlying && 32'(tx) == 32'(bulletX) && 32'(ty) == 32'(bulletY))
         obj_next = BULLET;
      else if (exploding && 32'(tx) == 32'(hitx_reg) && 32'(ty) == 32'(hity_reg))
         obj_next = EXPLODE;
      else if (32'(ty) == SHIP_ROW && 32'(tx) == 32'(shipX))
         obj_next = SHIP;
      else if (!inv_diff[CWY] && 32'(inv_diff) < INV_ROWS && invArray[inv_idx])
         obj_next = INVADER;
      else
         obj_next = BG;
   end

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         valid_reg <= 1'b0;
         obj_reg   <= OFF;
         par_reg   <= 1'b0;
         frame_reg <= 1'b0;
         px_reg    <= '0;
         py_reg    <= '0;
      end else begin
         valid_reg <= 1'b1;
         obj_reg   <= obj_next;
         par_reg   <= tx[0] ^ ty[0];
         frame_reg <= animFrame;
         px_reg    <= px;
         py_reg    <= py;
      end
   end

   vga_sprite_rom #(.TILE_LOG2(TILE_LOG2)) u_rom (
      .sprite     (obj_reg),
      .anim_frame (frame_reg),
      .py         (py_reg),
      .px         (px_reg),
      .on         (rom_bit)
   );

   always_comb begin
      case (obj_reg)
         BULLET:  rgb_next = rom_bit ? YELLOW  : BLUE;
         EXPLODE: rgb_next = rom_bit ? WHITE   : RED;
         SHIP:    rgb_next = rom_bit ? RED     : YELLOW;
         INVADER: rgb_next = rom_bit ? MAGENTA : GREEN;
         BG:      rgb_next = BLUE;
         CHECK:   rgb_next = par_reg ? WHITE : BLACK;
         default: rgb_next = BLACK;
      endcase
   end

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) rgb <= BLACK;
      else      rgb <= valid_reg ? rgb_next : BLACK;
   end

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         anim_cnt_reg <= '0;
         animFrame    <= 1'b0;
      end else if (frameStart) begin
         if (32'(anim_cnt_reg) == ANIM_DIV - 1) begin
            anim_cnt_reg <= '0;
            animFrame    <= ~animFrame;
         end else begin
            anim_cnt_reg <= anim_cnt_reg + AW'(1);
         end
      end
   end

   // a new hit always reloads, even when it lands on a frameStart
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         xstate_reg <= IDLE;
         xcnt_reg   <= '0;
         hitx_reg   <= '0;
         hity_reg   <= '0;
         exploding  <= 1'b0;
      end else if (hitValid) begin
         xstate_reg <= ACTIVE;
         xcnt_reg   <= EW'(EXPLODE_FRAMES);
         hitx_reg   <= hitX;
         hity_reg   <= hitY;
         exploding  <= 1'b1;
      end else if (xstate_reg == ACTIVE && frameStart) begin
         xcnt_reg <= xcnt_reg - EW'(1);
         if (xcnt_reg == EW'(1)) begin
            xstate_reg <= IDLE;
            exploding  <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_vga_sprite_renderer.sv
// Randomised and directed checks of the sprite renderer against a pixel-level reference model.
module tb_vga_sprite_renderer;

   localparam int COLS = 20, ROWS = 15, INV_ROWS = 3, SHIP_ROW = 13;
   localparam int ANIM_DIV = 2, EXPLODE_FRAMES = 8;

   logic        clk = 1'b0;
   logic        clr = 1'b0;
   logic [9:0]  VGAx = '0, VGAy = '0;
   logic        frameStart = 1'b0, attract = 1'b0;
   logic [59:0] invArray = '0;
   logic [3:0]  invLine = '0;
   logic [4:0]  shipX = '0, bulletX = '0, hitX = '0;
   logic [3:0]  bulletY = '0, hitY = '0;
   logic        bulletFlying = 1'b0, hitValid = 1'b0;
   logic [2:0]  rgb;
   logic        animFrame, exploding;

   int n_vec = 0;
   int n_err = 0;

   // reference model state
   int         m_cnt = 0, m_left = 0, m_hx = 0, m_hy = 0;
   bit         m_anim = 1'b0, m_v1 = 1'b0;
   logic [2:0] m_c1 = '0, m_rgb = '0;

   vga_sprite_renderer #(
      .TILE_LOG2(5), .COLS(COLS), .ROWS(ROWS), .INV_ROWS(INV_ROWS),
      .SHIP_ROW(SHIP_ROW), .ANIM_DIV(ANIM_DIV), .EXPLODE_FRAMES(EXPLODE_FRAMES)
   ) dut (
      .clk(clk), .clr(clr), .VGAx(VGAx), .VGAy(VGAy), .frameStart(frameStart),
      .attract(attract), .invArray(invArray), .invLine(invLine), .shipX(shipX),
      .bulletX(bulletX), .bulletY(bulletY), .bulletFlying(bulletFlying),
      .hitValid(hitValid), .hitX(hitX), .hitY(hitY),
      .rgb(rgb), .animFrame(animFrame), .exploding(exploding)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic bit in_box(int x, int y, int x0, int x1, int y0, int y1);
      return x >= x0 && x <= x1 && y >= y0 && y <= y1;
   endfunction

   function automatic int iabs(int v);
      return (v < 0) ? -v : v;
   endfunction

   // 0 bullet, 1 ship, 2 explosion, 3 invader
   function automatic bit sprite_bit(int kind, int x, int y, bit fr);
      bit body, legs;
      case (kind)
         0: return in_box(x, y, 14, 17, 4, 27);
         1: return in_box(x, y, 2, 29, 16, 27) || in_box(x, y, 13, 18, 6, 15);
         2: return iabs(x - y) <= 2 || iabs(x + y - 31) <= 2;
         default: begin
            body = in_box(x, y, 6, 25, 8, 19) && !in_box(x, y, 10, 12, 11, 13)
                   && !in_box(x, y, 19, 21, 11, 13);
            if (fr) legs = in_box(x, y, 11, 13, 20, 25) || in_box(x, y, 18, 20, 20, 25);
            else    legs = in_box(x, y, 6, 8, 20, 25) || in_box(x, y, 23, 25, 20, 25);
            return body || legs;
         end
      endcase
   endfunction

   function automatic logic [2:0] model_colour();
      int tx, ty, px, py, r;
      tx = int'(VGAx) / 32; ty = int'(VGAy) / 32;
      px = int'(VGAx) % 32; py = int'(VGAy) % 32;
      if (attract) return ((tx + ty) % 2 == 1) ? 3'b111 : 3'b000;
      if (tx >= COLS || ty >= ROWS) return 3'b000;
      if (bulletFlying && tx == int'(bulletX) && ty == int'(bulletY))
         return sprite_bit(0, px, py, m_anim) ? 3'b110 : 3'b001;
      if (m_left > 0 && tx == m_hx && ty == m_hy)
         return sprite_bit(2, px, py, m_anim) ? 3'b111 : 3'b100;
      if (ty == SHIP_ROW && tx == int'(shipX))
         return sprite_bit(1, px, py, m_anim) ? 3'b100 : 3'b110;
      r = ty - int'(invLine);
      if (r >= 0 && r < INV_ROWS && invArray[r * COLS + tx])
         return sprite_bit(3, px, py, m_anim) ? 3'b101 : 3'b010;
      return 3'b001;
   endfunction

   task automatic tick();
      logic [2:0] c;
      c = model_colour();
      @(posedge clk);
      m_rgb = m_v1 ? m_c1 : 3'b000;
      m_c1  = c;
      m_v1  = 1'b1;
      if (frameStart) begin
         if (m_cnt == ANIM_DIV - 1) begin
            m_cnt = 0;
            m_anim = ~m_anim;
         end else begin
            m_cnt++;
         end
      end
      if (hitValid) begin
         m_hx = int'(hitX); m_hy = int'(hitY); m_left = EXPLODE_FRAMES;
      end else if (m_left > 0 && frameStart) begin
         m_left--;
      end
      #1;
      check("rgb", 32'(rgb), 32'(m_rgb));
      check("animFrame", 32'(animFrame), 32'(m_anim));
      check("exploding", 32'(exploding), (m_left > 0) ? 32'd1 : 32'd0);
      $display("t=%0t x=%0d y=%0d fs=%0b hit=%0b rgb=%0d exp_rgb=%0d", $time, VGAx, VGAy,
               frameStart, hitValid, rgb, m_rgb);
   endtask

   task automatic set_pix(int tx, int ty, int px, int py);
      VGAx = 10'(tx * 32 + px);
      VGAy = 10'(ty * 32 + py);
   endtask

   task automatic frame_pulse();
      frameStart = 1'b1;
      tick();
      frameStart = 1'b0;
      tick();
   endtask

   initial begin
      // reset state
      repeat (3) @(posedge clk);
      #1;
      check("reset_rgb", 32'(rgb), 32'd0);
      check("reset_anim", 32'(animFrame), 32'd0);
      check("reset_expl", 32'(exploding), 32'd0);
      clr = 1'b1;

      // first valid pixel two clocks after release
      set_pix(3, 3, 10, 10);
      repeat (3) tick();

      // bullet beats ship on the same tile
      bulletX = 5'd5; shipX = 5'd5; bulletY = 4'd13; bulletFlying = 1'b1;
      VGAx = 10'd176; VGAy = 10'd430;
      repeat (3) tick();
      for (int i = 0; i < 6; i++) begin
         set_pix(5, 13, $urandom_range(0, 31), $urandom_range(0, 31));
         tick();
      end
      bulletFlying = 1'b0;
      for (int i = 0; i < 6; i++) begin
         set_pix(5, 13, $urandom_range(0, 31), $urandom_range(0, 31));
         tick();
      end

      // invader rows relative to invLine
      invLine = 4'd2; invArray = '0; invArray[1*20+7] = 1'b1;
      for (int i = 0; i < 6; i++) begin
         set_pix(7, 3, $urandom_range(0, 31), $urandom_range(0, 31));
         tick();
      end
      set_pix(7, 2, 16, 16); tick();
      set_pix(7, 5, 16, 16); tick();
      invLine = 4'd14; invArray = '1;
      for (int ty = 13; ty <= 16; ty++) begin
         set_pix(3, ty, 16, 22);
         tick();
      end

      // animation: invader leg pixels follow animFrame
      invLine = 4'd2;
      for (int f = 0; f < 6; f++) begin
         set_pix(4, 3, 7, 22); tick();
         set_pix(4, 3, 12, 22); tick();
         frame_pulse();
      end

      // explosion lifetime, relocation and reload-wins
      invArray = '0;
      hitX = 5'd4; hitY = 4'd3; hitValid = 1'b1;
      tick();
      hitValid = 1'b0;
      for (int f = 0; f < 5; f++) begin
         set_pix(4, 3, $urandom_range(0, 31), $urandom_range(0, 31));
         frame_pulse();
      end
      hitX = 5'd9; hitY = 4'd2; hitValid = 1'b1;
      tick();
      hitValid = 1'b0;
      for (int f = 0; f < 3; f++) begin
         set_pix(9, 2, 15, 15);
         frame_pulse();
      end
      hitValid = 1'b1; frameStart = 1'b1;
      tick();
      hitValid = 1'b0; frameStart = 1'b0;
      for (int f = 0; f < 10; f++) begin
         set_pix(9, 2, $urandom_range(0, 31), $urandom_range(0, 31));
         frame_pulse();
      end

      // attract checkerboard and off-grid blanking
      attract = 1'b1;
      for (int i = 0; i < 8; i++) begin
         VGAx = 10'($urandom_range(0, 639)); VGAy = 10'($urandom_range(0, 479));
         tick();
      end
      attract = 1'b0;
      VGAx = 10'd650; VGAy = 10'd100;
      repeat (3) tick();

      // asynchronous reset mid-line with live state
      hitX = 5'd1; hitY = 4'd1; hitValid = 1'b1; frameStart = 1'b1;
      set_pix(3, 3, 1, 1);
      tick();
      hitValid = 1'b0; frameStart = 1'b0;
      repeat (2) tick();
      #2 clr = 1'b0;
      #1;
      check("async_rgb", 32'(rgb), 32'd0);
      check("async_anim", 32'(animFrame), 32'd0);
      check("async_expl", 32'(exploding), 32'd0);
      m_cnt = 0; m_left = 0; m_anim = 1'b0; m_v1 = 1'b0; m_c1 = '0; m_rgb = '0;
      #1 clr = 1'b1;
      repeat (3) tick();

      // randomised traffic
      for (int n = 0; n < 1500; n++) begin
         if (n % 64 == 0) invArray = {$urandom, $urandom};
         attract      = ($urandom_range(0, 15) == 0);
         bulletFlying = $urandom_range(0, 1);
         bulletX      = 5'($urandom_range(0, COLS - 1));
         bulletY      = 4'($urandom_range(0, ROWS - 1));
         shipX        = 5'($urandom_range(0, COLS - 1));
         invLine      = 4'($urandom_range(0, ROWS - 1));
         frameStart   = ($urandom_range(0, 4) == 0);
         hitValid     = ($urandom_range(0, 39) == 0);
         hitX         = 5'($urandom_range(0, COLS - 1));
         hitY         = 4'($urandom_range(0, ROWS - 1));
         case ($urandom_range(0, 4))
            0: begin
               VGAx = 10'($urandom_range(0, 1023)); VGAy = 10'($urandom_range(0, 1023));
            end
            1: set_pix(int'(bulletX), int'(bulletY), $urandom_range(0, 31), $urandom_range(0, 31));
            2: set_pix(m_hx, m_hy, $urandom_range(0, 31), $urandom_range(0, 31));
            3: set_pix(int'(shipX), SHIP_ROW, $urandom_range(0, 31), $urandom_range(0, 31));
            default: set_pix($urandom_range(0, COLS - 1), int'(invLine) + $urandom_range(0, 2),
                             $urandom_range(0, 31), $urandom_range(0, 31));
         endcase
         tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
